rx_drain_sched: RTL and testbench

- Schedules the draining of the RX circular packet buffer toward the host DMA engine.
- Compares the producer write pointer against its own read pointer and issues bounded, non-wrapping read bursts over a req/ack/done handshake.
- Advances the committed read address only after each burst completes.
- Sits in the DMA-engine clock domain; committed_rd_address feeds the read-address clock-domain synchronizer back to the receive side.

---
 rtl/rx_drain_sched.sv | 106 ++++++++++
 tb/tb_rx_drain_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_drain_sched.sv
// Drains the RX circular buffer to the host DMA in bounded bursts that never wrap; the read pointer commits only after each burst is done.
// dma_req rises 1 cycle after the issue condition; the request is held until dma_ack, and only one burst is ever outstanding.
module rx_drain_sched #(
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_addr_in,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [ADDR_W:0]   dma_len,
  input  logic              dma_ack,
  input  logic              dma_done,
  output logic [ADDR_W-1:0] committed_rd_address,
  output logic              busy,
  output logic [15:0]       burst_count
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_COMMIT    = 2'd3;

  localparam logic [ADDR_W:0] MAX_LEN   = (ADDR_W+1)'(MAX_BURST);
  localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [15:0]     TIMEOUT_V = 16'(TIMEOUT);

  logic [1:0]        state;
  logic [15:0]       timer;
  logic [ADDR_W-1:0] occ;
  logic [ADDR_W:0]   occ_w;
  logic [ADDR_W:0]   room_to_end;
  logic [ADDR_W:0]   len;
  logic              issue;

  always_comb begin
    occ         = wr_addr_in - committed_rd_address;
    occ_w       = {1'b0, occ};
    room_to_end = DEPTH - {1'b0, committed_rd_address};
    len         = occ_w;
    if (len > MAX_LEN)     len = MAX_LEN;
    if (len > room_to_end) len = room_to_end;
    // Draining right up to the buffer end lets the next burst restart at line 0 without waiting for the timer.
    issue = (state == ST_IDLE) && enable && (occ_w != '0) &&
            ((occ_w >= MAX_LEN) || (timer == TIMEOUT_V) || (room_to_end <= occ_w));
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      dma_req              <= 1'b0;
      dma_addr             <= '0;
      dma_len              <= '0;
      committed_rd_address <= '0;
      burst_count          <= '0;
      timer                <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            dma_req  <= 1'b1;
            dma_addr <= committed_rd_address;
            dma_len  <= len;
            timer    <= '0;
            state    <= ST_REQ;
          end else if (occ_w == '0) begin
            timer <= '0;
          end else if ((occ_w < MAX_LEN) && (timer != TIMEOUT_V)) begin
            timer <= timer + 16'd1;
          end
        end
        ST_REQ: begin
          if (dma_ack) begin
            dma_req <= 1'b0;
            if (dma_done) begin
              committed_rd_address <= committed_rd_address + dma_len[ADDR_W-1:0];
              burst_count          <= burst_count + 16'd1;
              state                <= ST_COMMIT;
            end else begin
              state <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          // The pointer moves on the done edge so it is visible during the COMMIT cycle.
          if (dma_done) begin
            committed_rd_address <= committed_rd_address + dma_len[ADDR_W-1:0];
            burst_count          <= burst_count + 16'd1;
            state                <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          timer <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_drain_sched.sv
// Bench for rx_drain_sched: table of directed bursts, hand-written corner sequences, then random traffic against a reference model.
module tb_rx_drain_sched;

  localparam int AW    = 10;
  localparam int MB    = 16;
  localparam int TO    = 255;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] wr_addr_in;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [AW:0]   dma_len;
  logic          dma_ack;
  logic          dma_done;
  logic [AW-1:0] committed_rd_address;
  logic          busy;
  logic [15:0]   burst_count;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  rx_drain_sched #(.ADDR_W(AW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .wr_addr_in           (wr_addr_in),
    .dma_req              (dma_req),
    .dma_addr             (dma_addr),
    .dma_len              (dma_len),
    .dma_ack              (dma_ack),
    .dma_done             (dma_done),
    .committed_rd_address (committed_rd_address),
    .busy                 (busy),
    .burst_count          (burst_count)
  );

  typedef struct {
    int wr;
    int ack_wait;
    bit same;
    int addr;
    int len;
    int rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int wr, int ack_wait, bit same, int addr, int len, int rd);
    vec_t v;
    v.wr = wr; v.ack_wait = ack_wait; v.same = same;
    v.addr = addr; v.len = len; v.rd = rd;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (dma_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply(input vec_t v, input int exp_cnt);
    bit ok;
    wr_addr_in = AW'(v.wr);
    wait_req(ok);
    if (!ok) begin
      check("req_seen", 0, 1);
      return;
    end
    check("addr", int'(dma_addr), v.addr);
    check("len", int'(dma_len), v.len);
    repeat (v.ack_wait) @(negedge clk);
    check("req_held", int'(dma_req), 1);
    dma_ack  = 1'b1;
    dma_done = v.same;
    @(negedge clk);
    dma_ack  = 1'b0;
    dma_done = 1'b0;
    if (v.same) begin
      check("rd_same_cycle", int'(committed_rd_address), v.rd);
      check("req_low_same", int'(dma_req), 0);
    end else begin
      check("req_drop", int'(dma_req), 0);
      @(negedge clk);
      @(negedge clk);
      dma_done = 1'b1;
      @(negedge clk);
      dma_done = 1'b0;
      check("rd_commit", int'(committed_rd_address), v.rd);
    end
    check("burst_count", int'(burst_count), exp_cnt);
  endtask

  // Reference model state for the random phase
  int m_rd, m_cnt, m_wait, m_addr, m_len, m_wr;
  bit m_req_pending, m_in_flight, m_committing;

  task automatic model_commit();
    m_rd         = (m_rd + m_len) % DEPTH;
    m_cnt        = (m_cnt + 1) % 65536;
    m_committing = 1'b1;
  endtask

  initial begin
    bit ok;
    bit held;
    bit saw_req;
    int occ, room, step;
    bit exp_busy, mm;

    reset = 1'b1; enable = 1'b0; wr_addr_in = '0; dma_ack = 1'b0; dma_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", int'(dma_req), 0);
    check("rst_addr", int'(dma_addr), 0);
    check("rst_len", int'(dma_len), 0);
    check("rst_rd", int'(committed_rd_address), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(burst_count), 0);
    reset = 1'b0;
    enable = 1'b1;

    add(40, 0, 1'b0, 0, 16, 16);
    add(40, 3, 1'b0, 16, 16, 32);
    add(40, 0, 1'b1, 32, 8, 40);
    for (int k = 0; k < 61; k++) add(1020, k % 3, bit'(k % 2), 40 + 16 * k, 16, 56 + 16 * k);
    add(1020, 0, 1'b0, 1016, 4, 1020);
    add(10, 1, 1'b0, 1020, 4, 0);
    add(10, 0, 1'b0, 0, 10, 10);
    add(26, 0, 1'b1, 10, 16, 26);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

    // Ack withheld for 50 cycles while the producer jumps ahead
    wr_addr_in = 10'd66;
    wait_req(ok);
    check("hold_req_seen", int'(ok), 1);
    check("hold_addr", int'(dma_addr), 26);
    check("hold_len", int'(dma_len), 16);
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) wr_addr_in = 10'd166;
      if (!(dma_req && dma_addr == 10'd26 && dma_len == 11'd16)) held = 1'b0;
    end
    check("hold_stable", int'(held), 1);
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack = 1'b0;
    repeat (2) @(negedge clk);
    dma_done = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    check("hold_rd", int'(committed_rd_address), 42);

    // enable dropped during WAIT_DONE, 64 lines left behind
    wr_addr_in = 10'd122;
    wait_req(ok);
    check("en_req_seen", int'(ok), 1);
    check("en_addr", int'(dma_addr), 42);
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    dma_done = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    check("en_rd", int'(committed_rd_address), 58);
    check("en_cnt", int'(burst_count), 70);
    saw_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dma_req) saw_req = 1'b1;
    end
    check("en_no_req", int'(saw_req), 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_reassert_req", int'(dma_req), 1);
    check("en_reassert_addr", int'(dma_addr), 58);

    // Reset while WAIT_DONE, then a stray done
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack = 1'b0;
    enable = 1'b0;
    wr_addr_in = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dma_done = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    check("mid_rst_req", int'(dma_req), 0);
    check("mid_rst_addr", int'(dma_addr), 0);
    check("mid_rst_len", int'(dma_len), 0);
    check("mid_rst_rd", int'(committed_rd_address), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_cnt", int'(burst_count), 0);

    // Random traffic against the reference model
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_rd = 0; m_cnt = 0; m_wait = 0; m_addr = 0; m_len = 0; m_wr = 0;
    m_req_pending = 1'b0; m_in_flight = 1'b0; m_committing = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      exp_busy = m_req_pending | m_in_flight | m_committing;
      mm = (dma_req !== m_req_pending) ||
           (committed_rd_address !== AW'(m_rd)) ||
           (burst_count !== 16'(m_cnt)) ||
           (busy !== exp_busy) ||
           (m_req_pending && (dma_addr !== AW'(m_addr) || dma_len !== 11'(m_len)));
      nvec++;
      if (mm) begin
        nmis++;
        $display("FAIL rand cyc %0d: req %0d want %0d, addr %0d want %0d, len %0d want %0d, rd %0d want %0d, cnt %0d want %0d, busy %0d want %0d",
                 cyc, dma_req, m_req_pending, dma_addr, m_addr, dma_len, m_len,
                 committed_rd_address, m_rd, burst_count, m_cnt, busy, exp_busy);
      end

      enable = ($urandom_range(0, 9) != 0);
      occ = (m_wr - m_rd + DEPTH) % DEPTH;
      step = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      if (occ + step <= 1000) m_wr = (m_wr + step) % DEPTH;
      wr_addr_in = AW'(m_wr);
      if (m_req_pending) begin
        dma_ack  = ($urandom_range(0, 2) == 0);
        dma_done = dma_ack && ($urandom_range(0, 3) == 0);
      end else if (m_in_flight) begin
        dma_done = ($urandom_range(0, 3) == 0);
        dma_ack  = ($urandom_range(0, 7) == 0);
      end else begin
        dma_ack  = 1'b0;
        dma_done = 1'b0;
      end

      if (m_committing) begin
        m_committing = 1'b0;
        m_wait = 0;
      end else if (m_req_pending) begin
        if (dma_ack) begin
          m_req_pending = 1'b0;
          if (dma_done) model_commit();
          else m_in_flight = 1'b1;
        end
      end else if (m_in_flight) begin
        if (dma_done) begin
          m_in_flight = 1'b0;
          model_commit();
        end
      end else begin
        occ  = (m_wr - m_rd + DEPTH) % DEPTH;
        room = DEPTH - m_rd;
        if (enable && occ > 0 && (occ >= MB || m_wait >= TO || room <= occ)) begin
          m_req_pending = 1'b1;
          m_addr = m_rd;
          m_len  = (occ < MB) ? occ : MB;
          if (room < m_len) m_len = room;
          m_wait = 0;
        end else if (occ == 0) begin
          m_wait = 0;
        end else if (occ < MB) begin
          m_wait = m_wait + 1;
        end
      end
    end
    dma_ack = 1'b0;
    dma_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
